// File: rtl/ssd_mux_driver.sv
// ssd_mux_driver: time-multiplexed driver for an N-digit common-anode
// seven-segment bank. It latches 5-bit digit codes and scans one digit per
// slot. Each slot opens with an all-anodes-off interval to suppress ghosting.
// Leading-zero blanking is optional at run time.
// Optional build macro SSD_DP_EN adds the per-digit decimal-point input
// dp_in and the registered output dp_n.
module ssd_mux_driver #(
  parameter int N_DIGITS     = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [5*N_DIGITS-1:0] value_in,
  input  logic                  lzb_en,
`ifdef SSD_DP_EN
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic                  dp_n,
`endif
  output logic [6:0]            seg_n,
  output logic [N_DIGITS-1:0]   an_n
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_N = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

  logic [CW-1:0]                cnt_q, cnt_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [N_DIGITS-1:0][4:0]     value_q, value_d;
  logic [6:0]                   seg_n_q, seg_n_d;
  logic [N_DIGITS-1:0]          an_n_q, an_n_d;
  logic [N_DIGITS-1:0]          lz_blank;
  logic [4:0]                   code;
  logic                         dark;

  // Segment decode; codes above 0xF show nothing.
  function automatic logic [6:0] seg_decode(input logic [4:0] c);
    case (c)
      5'h00: seg_decode = 7'h40;
      5'h01: seg_decode = 7'h79;
      5'h02: seg_decode = 7'h24;
      5'h03: seg_decode = 7'h30;
      5'h04: seg_decode = 7'h19;
      5'h05: seg_decode = 7'h12;
      5'h06: seg_decode = 7'h02;
      5'h07: seg_decode = 7'h78;
      5'h08: seg_decode = 7'h00;
      5'h09: seg_decode = 7'h18;
      5'h0A: seg_decode = 7'h08;
      5'h0B: seg_decode = 7'h03;
      5'h0C: seg_decode = 7'h46;
      5'h0D: seg_decode = 7'h21;
      5'h0E: seg_decode = 7'h06;
      5'h0F: seg_decode = 7'h0E;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // Slot counter and digit index; both freeze while en is low.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_MAX) ? '0 : IW'(idx_q + 1'b1);
      end else begin
        cnt_d = CW'(cnt_q + 1'b1);
      end
    end
  end

  // Digit capture on the load strobe.
  always_comb begin
    value_d = value_q;
    if (load) value_d = value_in;
  end

  // Leading-zero run from the top digit down; digit 0 is never blanked.
  always_comb begin
    logic run;
    run      = 1'b1;
    lz_blank = '0;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      run         = run & (value_q[k] == 5'h00);
      lz_blank[k] = run;
    end
  end

  // Next pin values from the current scan state.
  always_comb begin
    dark = !en || (cnt_q < BLANK_N);
    code = value_q[idx_q];
    if (lzb_en && lz_blank[idx_q]) code = 5'h1F;
    if (dark) begin
      seg_n_d = 7'h7F;
      an_n_d  = '1;
    end else begin
      seg_n_d = seg_decode(code);
      an_n_d  = ~(N_DIGITS'(1) << idx_q);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      value_q <= {N_DIGITS{5'h1F}};
      seg_n_q <= 7'h7F;
      an_n_q  <= '1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      seg_n_q <= seg_n_d;
      an_n_q  <= an_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign an_n  = an_n_q;

`ifdef SSD_DP_EN
  logic [N_DIGITS-1:0] dp_q, dp_d;
  logic                dp_n_q, dp_n_d;

  // Decimal points ride along with the digit codes; leading-zero blanking
  // does not suppress them.
  always_comb begin
    dp_d   = load ? dp_in : dp_q;
    dp_n_d = dark ? 1'b1 : ~dp_q[idx_q];
  end

  // Decimal-point registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_q   <= '0;
      dp_n_q <= 1'b1;
    end else begin
      dp_q   <= dp_d;
      dp_n_q <= dp_n_d;
    end
  end

  assign dp_n = dp_n_q;
`endif

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Bench for ssd_mux_driver (N_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2).
// A time-based model derives slot and position from the count of enabled
// cycles and is compared every cycle; directed literal checks pin the model.
module tb_ssd_mux_driver;
  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic           load = 1'b0;
  logic           lzb_en = 1'b0;
  logic [5*N-1:0] value_in = '0;
  logic [N-1:0]   dp_val = '0;
  logic [6:0]     seg_n;
  logic [N-1:0]   an_n;
`ifdef SSD_DP_EN
  logic [N-1:0]   dp_in;
  logic           dp_n;
  logic           exp_dp = 1'b1;
  logic [N-1:0]   mdp = '0;
  assign dp_in = dp_val;
`endif

  ssd_mux_driver #(.N_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value_in(value_in),
    .lzb_en(lzb_en),
`ifdef SSD_DP_EN
    .dp_in(dp_in), .dp_n(dp_n),
`endif
    .seg_n(seg_n), .an_n(an_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         t = 0;                 // enabled cycles since reset
  logic [4:0] mv [N];
  logic [6:0] exp_seg = 7'h7F;
  logic [N-1:0] exp_an = '1;

  function automatic bit zeros_from(input int k);
    for (int j = k; j < N; j++) if (mv[j] != 5'h00) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0;
      for (int k = 0; k < N; k++) mv[k] = 5'h1F;
      exp_seg = 7'h7F;
      exp_an  = '1;
`ifdef SSD_DP_EN
      mdp = '0;
      exp_dp = 1'b1;
`endif
    end else begin
      int slot, pos;
      logic [4:0] c;
      slot = (t / P) % N;
      pos  = t % P;
      if (!en || pos < B) begin
        exp_seg = 7'h7F;
        exp_an  = '1;
`ifdef SSD_DP_EN
        exp_dp = 1'b1;
`endif
      end else begin
        c = mv[slot];
        if (lzb_en && slot > 0 && zeros_from(slot)) c = 5'h1F;
        exp_seg = (c < 16) ? SEG[c[3:0]] : 7'h7F;
        exp_an  = '1;
        exp_an[slot] = 1'b0;
`ifdef SSD_DP_EN
        exp_dp = ~mdp[slot];
`endif
      end
      if (en) t++;
      if (load) begin
        for (int k = 0; k < N; k++) mv[k] = value_in[5*k +: 5];
`ifdef SSD_DP_EN
        mdp = dp_val;
`endif
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("seg_n", {25'd0, seg_n}, {25'd0, exp_seg});
    chk("an_n", {28'd0, an_n}, {28'd0, exp_an});
`ifdef SSD_DP_EN
    chk("dp_n", {31'd0, dp_n}, {31'd0, exp_dp});
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [5*N-1:0] v, input logic [N-1:0] d);
    load = 1'b1; value_in = v; dp_val = d;
    tick(1);
    load = 1'b0;
  endtask

  // Wait (bounded) for an anode pattern, then check the segments shown.
  task automatic wait_an(input string name, input logic [N-1:0] a, input logic [6:0] s);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an_n === a) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting an_n=%0h last %0h", name, a, an_n);
    end else begin
      chk(name, {25'd0, seg_n}, {25'd0, s});
    end
  endtask

  initial begin
    int n;
    // 1. reset and idle
    #1 rst = 1'b1;
    tick(2);
    chk("rst_seg", {25'd0, seg_n}, 32'h7F);
    chk("rst_an", {28'd0, an_n}, 32'hF);
    rst = 1'b0; en = 1'b1;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (seg_n !== 7'h7F) n++;
    end
    chk("idle_lit_segs", n, 0);
    @(posedge clk); #1;

    // 2. basic scan
    do_load({5'h1, 5'h2, 5'h3, 5'h4}, '0);
    tick(N * P);
    wait_an("scan_d0", 4'hE, 7'h19);
    wait_an("scan_d1", 4'hD, 7'h30);
    wait_an("scan_d2", 4'hB, 7'h24);
    wait_an("scan_d3", 4'h7, 7'h79);
    wait_an("scan_wrap", 4'hE, 7'h19);
    // mid-slot asynchronous reset
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_seg", {25'd0, seg_n}, 32'h7F);
    chk("rst_mid_an", {28'd0, an_n}, 32'hF);
    @(posedge clk); #1 rst = 1'b0;

    // 3. leading-zero blanking
    lzb_en = 1'b1;
    do_load({5'h0, 5'h0, 5'hA, 5'h0}, '0);
    tick(N * P);
    wait_an("lzb_d0", 4'hE, 7'h40);
    wait_an("lzb_d1", 4'hD, 7'h08);
    wait_an("lzb_d2", 4'hB, 7'h7F);
    wait_an("lzb_d3", 4'h7, 7'h7F);
    @(posedge clk); #1;
    do_load({5'h0, 5'h0, 5'h0, 5'h0}, '0);
    tick(N * P);
    wait_an("lzb0_d1", 4'hD, 7'h7F);
    wait_an("lzb0_d0", 4'hE, 7'h40);

    // 4. enable freeze at cnt=4 of digit 2
    wait_an("frz_d2", 4'hB, 7'h7F);
    @(posedge clk); #1;
    en = 1'b0;
    tick(1);
    chk("frz_blank_an", {28'd0, an_n}, 32'hF);
    tick(9);
    en = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (an_n === 4'hB) n++;
    end
    chk("frz_resume_lit", n, 4);
    @(posedge clk); #1;

    // 5. out-of-range code, then mid-slot load
    lzb_en = 1'b0;
    do_load({5'h1F, 5'h1F, 5'h1F, 5'h15}, 4'b0010);
    tick(N * P);
    wait_an("oor_d0", 4'hE, 7'h7F);
    @(posedge clk); #1;
    do_load({5'h1F, 5'h1F, 5'h1F, 5'h08}, 4'b0010);
    tick(1);
    chk("midload_seg", {25'd0, seg_n}, 32'h00);
    chk("midload_an", {28'd0, an_n}, 32'hE);

`ifdef SSD_DP_EN
    // 6. decimal point on digit 1 only
    wait_an("dp_d1", 4'hD, 7'h7F);
    chk("dp_lit", {31'd0, dp_n}, 32'h0);
    tick(2 * N * P);
`else
    tick(N * P);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
